// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (IF) and load/store (MEM) share one
// memory-controller port, with MEM priority bounded by a starvation counter for IF.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_IF_req,
  input  logic [ADDR_W-1:0]   i_IF_addr,
  output logic                o_IF_busy,
  output logic                o_IF_valid,
  output logic [DATA_W-1:0]   o_IF_inst,
  output logic [ADDR_W-1:0]   o_IF_addr,
  input  logic                i_MEM_req,
  input  logic                i_MEM_we,
  input  logic [ADDR_W-1:0]   i_MEM_addr,
  input  logic [DATA_W-1:0]   i_MEM_wdata,
  input  logic [DATA_W/8-1:0] i_MEM_wmask,
  output logic                o_MEM_busy,
  output logic                o_MEM_valid,
  output logic [DATA_W-1:0]   o_MEM_rdata,
  output logic [1:0]          o_MC_rw_flag,
  output logic [ADDR_W-1:0]   o_MC_addr,
  output logic [DATA_W-1:0]   o_MC_write_data,
  output logic [DATA_W/8-1:0] o_MC_write_mask,
  input  logic                i_MC_busy,
  input  logic                i_MC_done,
  input  logic [DATA_W-1:0]   i_MC_read_data
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ownerMem_q, ownerMem_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                ifValid_q, ifValid_d;
  logic                memValid_q, memValid_d;
  logic [DATA_W-1:0]   ifInst_q, ifInst_d;
  logic [ADDR_W-1:0]   ifAddr_q, ifAddr_d;
  logic [DATA_W-1:0]   memRdata_q, memRdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ownerMem_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      starve_q   <= '0;
      ifValid_q  <= 1'b0;
      memValid_q <= 1'b0;
      ifInst_q   <= '0;
      ifAddr_q   <= '0;
      memRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ownerMem_q <= ownerMem_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      starve_q   <= starve_d;
      ifValid_q  <= ifValid_d;
      memValid_q <= memValid_d;
      ifInst_q   <= ifInst_d;
      ifAddr_q   <= ifAddr_d;
      memRdata_q <= memRdata_d;
    end
  end

  // Requesters answer a valid pulse within that same cycle, so IDLE arbitrates on the raw
  // request lines and back-to-back MEM traffic can genuinely starve IF.
  always_comb begin
    state_d    = state_q;
    ownerMem_d = ownerMem_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    starve_d   = starve_q;
    ifValid_d  = 1'b0;
    memValid_d = 1'b0;
    ifInst_d   = ifInst_q;
    ifAddr_d   = ifAddr_q;
    memRdata_d = memRdata_q;

    case (state_q)
      IDLE: begin
        if (i_MEM_req && !(i_IF_req && starve_q == STARVE_LIM)) begin
          state_d    = ISSUE;
          ownerMem_d = 1'b1;
          we_d       = i_MEM_we;
          addr_d     = i_MEM_addr;
          wdata_d    = i_MEM_wdata;
          wmask_d    = i_MEM_wmask;
          if (!i_IF_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (i_IF_req) begin
          state_d    = ISSUE;
          ownerMem_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = i_IF_addr;
          wdata_d    = '0;
          wmask_d    = '0;
          starve_d   = '0;
        end
      end
      ISSUE: begin
        if (!i_MC_busy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_MC_done) begin
          state_d = IDLE;
          if (ownerMem_q) begin
            memValid_d = 1'b1;
            if (!we_q) begin
              memRdata_d = i_MC_read_data;
            end
          end else begin
            ifValid_d = 1'b1;
            ifInst_d  = i_MC_read_data;
            ifAddr_d  = addr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The controller command is only presented while ISSUE waits for acceptance.
  always_comb begin
    o_MC_rw_flag    = 2'b00;
    o_MC_addr       = '0;
    o_MC_write_data = '0;
    o_MC_write_mask = '0;
    if (state_q == ISSUE) begin
      o_MC_rw_flag = we_q ? 2'b10 : 2'b01;
      o_MC_addr    = addr_q;
      if (we_q) begin
        o_MC_write_data = wdata_q;
        o_MC_write_mask = wmask_q;
      end
    end
  end

  assign o_IF_busy   = rst_n & i_IF_req & ~ifValid_q;
  assign o_MEM_busy  = rst_n & i_MEM_req & ~memValid_q;
  assign o_IF_valid  = ifValid_q;
  assign o_MEM_valid = memValid_q;
  assign o_IF_inst   = ifInst_q;
  assign o_IF_addr   = ifAddr_q;
  assign o_MEM_rdata = memRdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers push expected responses, a monitor
// pops them on every valid pulse, and a memory-controller model checks each command.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_IF_req;
  logic [31:0] i_IF_addr;
  logic        o_IF_busy, o_IF_valid;
  logic [31:0] o_IF_inst, o_IF_addr;
  logic        i_MEM_req, i_MEM_we;
  logic [31:0] i_MEM_addr, i_MEM_wdata;
  logic [3:0]  i_MEM_wmask;
  logic        o_MEM_busy, o_MEM_valid;
  logic [31:0] o_MEM_rdata;
  logic [1:0]  o_MC_rw_flag;
  logic [31:0] o_MC_addr, o_MC_write_data;
  logic [3:0]  o_MC_write_mask;
  logic        i_MC_busy, i_MC_done;
  logic [31:0] i_MC_read_data;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_IF_req(i_IF_req), .i_IF_addr(i_IF_addr), .o_IF_busy(o_IF_busy),
    .o_IF_valid(o_IF_valid), .o_IF_inst(o_IF_inst), .o_IF_addr(o_IF_addr),
    .i_MEM_req(i_MEM_req), .i_MEM_we(i_MEM_we), .i_MEM_addr(i_MEM_addr),
    .i_MEM_wdata(i_MEM_wdata), .i_MEM_wmask(i_MEM_wmask), .o_MEM_busy(o_MEM_busy),
    .o_MEM_valid(o_MEM_valid), .o_MEM_rdata(o_MEM_rdata),
    .o_MC_rw_flag(o_MC_rw_flag), .o_MC_addr(o_MC_addr),
    .o_MC_write_data(o_MC_write_data), .o_MC_write_mask(o_MC_write_mask),
    .i_MC_busy(i_MC_busy), .i_MC_done(i_MC_done), .i_MC_read_data(i_MC_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] ifExpAddrQ[$];
  logic [31:0] ifExpInstQ[$];
  logic [31:0] memExpQ[$];
  logic [31:0] lastLoad = 32'h0;

  bit          ifPend = 0, memPend = 0, memPendWe = 0;
  bit          ifGranted = 0, memGranted = 0;
  logic [31:0] ifPendAddr, memPendAddr, memPendWdata;
  logic [3:0]  memPendWmask;

  bit          mcEnable = 1, manDone = 0;
  logic [31:0] manData = 32'h0;
  int          forceStall = -1, forceDelay = -1;
  int          issueCycles = 0;
  int          lastIfLat = 0;
  logic [31:0] cmdLog[$];
  int          ifValidCount = 0, memValidCount = 0;

  logic [31:0] monAddr, monData;
  logic [31:0] expOrder[$];
  int          cnt, mi, ii, ifBefore, memBefore;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s", name);
  endtask

  // Contents the controller returns for a read at a given address.
  function automatic logic [31:0] rdFn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  task automatic ifFetch(input logic [31:0] a);
    bit got = 0;
    ifPendAddr = a;
    ifPend     = 1;
    ifGranted  = 0;
    ifExpAddrQ.push_back(a);
    ifExpInstQ.push_back(rdFn(a));
    i_IF_req  = 1'b1;
    i_IF_addr = a;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (o_IF_valid) begin
        got = 1;
        lastIfLat = c + 1;
      end else if (ifGranted) begin
        i_IF_addr = $urandom;
      end
    end
    i_IF_req = 1'b0;
    ifPend   = 0;
    if (!got) failNow("ifTimeout");
  endtask

  task automatic memAccess(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] wm, input bit mayDrop);
    bit got = 0;
    memPend      = 1;
    memPendWe    = we;
    memPendAddr  = a;
    memPendWdata = wd;
    memPendWmask = wm;
    memGranted   = 0;
    if (!we) lastLoad = rdFn(a);
    memExpQ.push_back(lastLoad);
    i_MEM_req   = 1'b1;
    i_MEM_we    = we;
    i_MEM_addr  = a;
    i_MEM_wdata = wd;
    i_MEM_wmask = wm;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (o_MEM_valid) begin
        got = 1;
      end else if (memGranted) begin
        i_MEM_addr  = $urandom;
        i_MEM_wdata = $urandom;
        i_MEM_wmask = 4'($urandom_range(0, 15));
        i_MEM_we    = 1'($urandom_range(0, 1));
        if (mayDrop && $urandom_range(0, 3) == 0) i_MEM_req = 1'b0;
      end
    end
    i_MEM_req = 1'b0;
    memPend   = 0;
    if (!got) failNow("memTimeout");
  endtask

  // Serve one command: identify its owner, stall it, then return done after a delay.
  task automatic mcServe();
    logic [1:0]  f;
    logic [31:0] a, wd;
    logic [3:0]  wm;
    int          stall, dly;
    bit          memMatch, ifMatch;
    f  = o_MC_rw_flag;
    a  = o_MC_addr;
    wd = o_MC_write_data;
    wm = o_MC_write_mask;
    cmdLog.push_back(a);
    if (f == 2'b10) begin
      checkOutput("storeOwner", {31'b0, memPend && memPendWe}, 64'd1);
      checkOutput("storeAddr", a, memPendAddr);
      checkOutput("storeData", wd, memPendWdata);
      checkOutput("storeMask", wm, memPendWmask);
      memGranted = 1;
    end else begin
      checkOutput("readFlag", f, 2'b01);
      checkOutput("readWriteFields", {wm, wd}, 36'h0);
      memMatch = memPend && !memPendWe && (a == memPendAddr);
      ifMatch  = ifPend && (a == ifPendAddr);
      checkOutput("readOwner", {31'b0, memMatch || ifMatch}, 64'd1);
      if (memMatch) memGranted = 1;
      else if (ifMatch) ifGranted = 1;
    end
    stall = (forceStall >= 0) ? forceStall : $urandom_range(0, 2);
    dly   = (forceDelay >= 0) ? forceDelay : $urandom_range(0, 2);
    issueCycles = 1;
    i_MC_busy      = (stall != 0);
    i_MC_done      = 1'($urandom_range(0, 1));
    i_MC_read_data = $urandom;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (o_MC_rw_flag != 2'b00) issueCycles++;
      checkOutput("issueHold", {o_MC_rw_flag, o_MC_addr}, {f, a});
      i_MC_busy      = (k < stall - 1);
      i_MC_done      = 1'($urandom_range(0, 1));
      i_MC_read_data = $urandom;
    end
    @(negedge clk);
    i_MC_done = 1'b0;
    checkOutput("flagAfterAccept", o_MC_rw_flag, 2'b00);
    repeat (dly) @(negedge clk);
    @(negedge clk);
    i_MC_done      = 1'b1;
    i_MC_read_data = (f == 2'b10) ? $urandom : rdFn(a);
    @(negedge clk);
    i_MC_done      = 1'b0;
    i_MC_read_data = $urandom;
  endtask

  initial begin
    i_MC_busy      = 1'b0;
    i_MC_done      = 1'b0;
    i_MC_read_data = 32'h0;
    forever begin
      @(negedge clk);
      if (!mcEnable) begin
        i_MC_busy      = 1'b0;
        i_MC_done      = manDone;
        i_MC_read_data = manData;
      end else if (rst_n) begin
        i_MC_done = 1'b0;
        if (o_MC_rw_flag != 2'b00) begin
          mcServe();
        end else if ($urandom_range(0, 3) == 0) begin
          i_MC_done      = 1'b1;
          i_MC_read_data = $urandom;
        end
      end
    end
  end

  // Scoreboard monitor: every valid pulse consumes exactly one expected response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_IF_valid) begin
        ifValidCount++;
        if (ifExpAddrQ.size() == 0) begin
          failNow("ifValidUnexpected");
        end else begin
          monAddr = ifExpAddrQ.pop_front();
          monData = ifExpInstQ.pop_front();
          checkOutput("ifInst", o_IF_inst, monData);
          checkOutput("ifAddr", o_IF_addr, monAddr);
        end
      end
      if (o_MEM_valid) begin
        memValidCount++;
        if (memExpQ.size() == 0) begin
          failNow("memValidUnexpected");
        end else begin
          monData = memExpQ.pop_front();
          checkOutput("memRdata", o_MEM_rdata, monData);
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      checkOutput("ifBusy", o_IF_busy, i_IF_req && !o_IF_valid);
      checkOutput("memBusy", o_MEM_busy, i_MEM_req && !o_MEM_valid);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input int n);
    fork
      begin
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          ifFetch({20'h0, 10'($urandom_range(0, 1023)), 2'b00});
        end
      end
      begin
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          memAccess(1'($urandom_range(0, 2) == 0),
                    32'h0001_0000 + {18'h0, 12'($urandom_range(0, 4095)), 2'b00},
                    $urandom, 4'($urandom_range(0, 15)), 1'b1);
        end
      end
    join
  endtask

  initial begin
    rst_n = 1'b0;
    i_IF_req = 1'b0; i_IF_addr = 32'h0;
    i_MEM_req = 1'b0; i_MEM_we = 1'b0; i_MEM_addr = 32'h0;
    i_MEM_wdata = 32'h0; i_MEM_wmask = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("rstFlag", o_MC_rw_flag, 2'b00);
    checkOutput("rstValids", {o_IF_valid, o_MEM_valid}, 2'b00);
    checkOutput("rstIfInst", o_IF_inst, 32'h0);
    checkOutput("rstIfAddr", o_IF_addr, 32'h0);
    checkOutput("rstMemRdata", o_MEM_rdata, 32'h0);
    checkOutput("rstMcAddr", o_MC_addr, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single fetch with no stall: flag for one cycle, valid four cycles after request.
    forceStall = 0; forceDelay = 0;
    cmdLog.delete();
    ifFetch(32'h100);
    checkOutput("fetchLatency", lastIfLat, 4);
    checkOutput("fetchIssueCycles", issueCycles, 1);
    checkOutput("fetchCmdAddr", cmdLog[0], 32'h100);

    // Simultaneous requests: MEM first, then IF, one valid each.
    cmdLog.delete();
    ifBefore = ifValidCount; memBefore = memValidCount;
    fork
      ifFetch(32'h200);
      memAccess(1'b0, 32'h1000, 32'h1234_5678, 4'hF, 1'b0);
    join
    checkOutput("simulCmdCount", cmdLog.size(), 2);
    checkOutput("simulFirst", cmdLog[0], 32'h1000);
    checkOutput("simulSecond", cmdLog[1], 32'h200);
    checkOutput("simulIfValids", ifValidCount - ifBefore, 1);
    checkOutput("simulMemValids", memValidCount - memBefore, 1);

    // Store: rdata must keep the last load value.
    memAccess(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    checkOutput("storeKeepsRdata", o_MEM_rdata, rdFn(32'h1000));

    // Controller busy for three ISSUE cycles.
    forceStall = 3;
    memAccess(1'b0, 32'h1100, 32'h0, 4'h0, 1'b0);
    checkOutput("stallIssueCycles", issueCycles, 4);
    forceStall = 0;

    // Back-to-back MEM loads against two back-to-back fetches.
    cmdLog.delete();
    expOrder.delete();
    cnt = 0; mi = 0; ii = 0;
    while (mi < 8 || ii < 2) begin
      if (mi < 8 && !(ii < 2 && cnt == STARVE)) begin
        expOrder.push_back(32'h3000 + 32'(4 * mi));
        mi++;
        cnt = (ii < 2) ? ((cnt < STARVE) ? cnt + 1 : STARVE) : 0;
      end else begin
        expOrder.push_back(32'h400 + 32'(4 * ii));
        ii++;
        cnt = 0;
      end
    end
    fork
      for (int k = 0; k < 2; k++) ifFetch(32'h400 + 32'(4 * k));
      for (int k = 0; k < 8; k++) memAccess(1'b0, 32'h3000 + 32'(4 * k), $urandom, 4'hF, 1'b0);
    join
    checkOutput("starveCmdCount", cmdLog.size(), expOrder.size());
    for (int k = 0; k < expOrder.size() && k < cmdLog.size(); k++)
      checkOutput($sformatf("starveOrder%0d", k), cmdLog[k], expOrder[k]);

    forceStall = -1; forceDelay = -1;
    applyStimulus(30);

    // Reset while a fetch waits for done; late done must produce nothing.
    mcEnable = 0; manDone = 0;
    repeat (2) @(negedge clk);
    i_IF_req = 1'b1; i_IF_addr = 32'h300;
    @(negedge clk);
    checkOutput("rstTestIssue", o_MC_rw_flag, 2'b01);
    @(negedge clk);
    checkOutput("rstTestWait", o_MC_rw_flag, 2'b00);
    ifBefore = ifValidCount;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstFlag", o_MC_rw_flag, 2'b00);
    checkOutput("midRstOuts", {o_IF_valid, o_MEM_valid, o_IF_busy, o_MEM_busy}, 4'b0);
    checkOutput("midRstIfInst", o_IF_inst, 32'h0);
    checkOutput("midRstMemRdata", o_MEM_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    i_IF_req = 1'b0;
    manData = 32'hCAFE_F00D;
    manDone = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) manDone = 0;
      checkOutput("postRstValid", {o_IF_valid, o_MEM_valid}, 2'b00);
      checkOutput("postRstInst", o_IF_inst, 32'h0);
      checkOutput("postRstFlag", o_MC_rw_flag, 2'b00);
    end
    checkOutput("postRstIfValids", ifValidCount - ifBefore, 0);
    mcEnable = 1;
    @(negedge clk);
    ifFetch(32'h104);

    repeat (4) @(negedge clk);
    checkOutput("ifQueueEmpty", ifExpAddrQ.size(), 0);
    checkOutput("memQueueEmpty", memExpQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data/instruction width.
REQ-003 SHALL have parameter STARVE_MAX, 4, consecutive MEM grants allowed while IF waits.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_IF_req  in  1  fetch request; held until o_IF_valid.
REQ-007 i_IF_addr  in  ADDR_W  fetch address.
REQ-008 o_IF_busy  out  1  fetch pending, not yet complete.
REQ-009 o_IF_valid  out  1  one-cycle fetch completion pulse.
REQ-010 o_IF_inst / o_IF_addr  out  DATA_W / ADDR_W  fetched word and its address.
REQ-011 i_MEM_req, i_MEM_we  in  1 each  load/store request (we=1 store); held until o_MEM_valid.
REQ-012 i_MEM_addr, i_MEM_wdata, i_MEM_wmask  in  ADDR_W, DATA_W, DATA_W/8  access address, store data, byte mask.
REQ-013 o_MEM_busy, o_MEM_valid  out  1 each  pending flag; one-cycle completion pulse.
REQ-014 o_MEM_rdata  out  DATA_W  load data.
REQ-015 o_MC_rw_flag  out  2  00 idle, 01 read, 10 write.
REQ-016 o_MC_addr, o_MC_write_data, o_MC_write_mask  out  ADDR_W, DATA_W, DATA_W/8  controller command.
REQ-017 i_MC_busy, i_MC_done, i_MC_read_data  in  1, 1, DATA_W  controller status and read data.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE; one transaction outstanding at most.
REQ-019 IDLE: no request -> stay; else grant, latch owner, addr, we, wdata, wmask, go ISSUE next edge.
REQ-020 Arbitration: MEM wins when both request, unless starve count == STARVE_MAX, then IF wins.
REQ-021 Starve count: +1 per MEM grant while i_IF_req high; cleared on IF grant or IF idle at grant; saturates at STARVE_MAX.
REQ-022 ISSUE: o_MC_rw_flag = 01 (IF or MEM load) or 10 (store), command fields from latched values; held while i_MC_busy=1.
REQ-023 ISSUE with i_MC_busy=0 at edge: command accepted, go WAIT; rw_flag 00 from next cycle.
REQ-024 WAIT: on i_MC_done=1, capture i_MC_read_data into owner's data output (not for store), pulse owner's valid next cycle, go IDLE.
REQ-025 Latency: no MC stall, done one cycle after accept -> valid 4 cycles after request seen in IDLE.
REQ-026 Requester inputs changed after grant SHALL be ignored until completion.
REQ-027 Requester dropping req mid-transaction: transaction completes, valid still pulses.
REQ-028 o_X_busy = i_X_req and not o_X_valid that cycle.
REQ-029 Store completion: o_MEM_valid pulses, o_MEM_rdata unchanged.
REQ-030 Data outputs SHALL hold last captured value between transactions.
REQ-031 i_MC_done in IDLE/ISSUE SHALL be ignored.
REQ-032 o_MC_write_data/mask SHALL be 0 on reads.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, starve count 0, all outputs 0 (rw_flag 00, valids 0, data 0).
REQ-034 Reset mid-transaction SHALL abandon it; no valid pulse after release; first IDLE cycle re-arbitrates.

Verification
REQ-035 IF-only fetch 0x100, MC done 1 cycle after accept, read data 0x00000013 -> rw_flag 01 addr 0x100 one cycle, o_IF_valid pulse with inst 0x00000013, addr 0x100.
REQ-036 Simultaneous IF 0x200 and MEM load 0x1000 -> MEM first (rw_flag 01 addr 0x1000), then IF; each valid pulses once.
REQ-037 MEM store 0x2004, wdata 0xDEADBEEF, mask 0011 -> rw_flag 10, write_data 0xDEADBEEF, mask 0011; o_MEM_valid pulse, rdata unchanged.
REQ-038 MEM requests every cycle, IF held high -> after 4 MEM grants IF granted 5th; count returns 0.
REQ-039 i_MC_busy high 3 cycles in ISSUE -> rw_flag held 3 cycles, addr stable, accept on 4th edge.
REQ-040 rst_n low during WAIT, done arrives after release -> no valid, outputs 0, FSM IDLE.
